// File: rtl/quant_writeback.sv
// quant_writeback: writes quantized rows into SRAM, one SRAM word per cycle.
//
// A job is started by a one-cycle start pulse. It writes row_total rows to consecutive SRAM words
// starting at base_addr. Each accepted row is split into WPR words. Word k carries lanes k*LPW..
// k*LPW+LPW-1, with lane 0 of the word in the low bits. Word addresses wrap modulo 2^ADDR_WIDTH.
//
// Build option:
//   QUANT_WB_RELU_EN  when defined, negative lanes are clamped to 0 as a row is accepted.
//
// Ports:
//   clk, rst_n        clock and asynchronous active-low reset
//   start             one-cycle job start (ignored unless idle)
//   base_addr         first SRAM word address of the job (sampled on start)
//   row_total         number of rows in the job (sampled on start)
//   in_valid/in_data  quantized row input; lane i at in_data[i*OUTPUT_DATA_WIDTH +: ...]
//   in_ready          row is accepted on in_valid && in_ready
//   sram_wen          SRAM write strobe
//   sram_waddr        SRAM write address
//   sram_wdata        SRAM write data (address and data hold their last values when idle)
//   busy              job in progress
//   done              one-cycle completion pulse
module quant_writeback #(
   parameter int unsigned ARRAY_SIZE        = 8,
   parameter int unsigned OUTPUT_DATA_WIDTH = 16,
   parameter int unsigned SRAM_DATA_WIDTH   = 32,
   parameter int unsigned ADDR_WIDTH        = 10
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic [ADDR_WIDTH-1:0]                 base_addr,
   input  logic [7:0]                            row_total,
   input  logic                                  in_valid,
   input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] in_data,
   output logic                                  in_ready,
   output logic                                  sram_wen,
   output logic [ADDR_WIDTH-1:0]                 sram_waddr,
   output logic [SRAM_DATA_WIDTH-1:0]            sram_wdata,
   output logic                                  busy,
   output logic                                  done
);

   localparam int unsigned ROW_W = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
   localparam int unsigned WPR   = ROW_W / SRAM_DATA_WIDTH;
   localparam int unsigned WCW   = (WPR > 1) ? $clog2(WPR) : 1;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_base;
   logic [7:0]            r_row_total;
   logic [7:0]            r_row_idx;
   logic [WCW-1:0]        r_word_cnt;
   logic [ROW_W-1:0]      r_row_buf;
   logic [ADDR_WIDTH-1:0] r_hold_addr;
   logic [SRAM_DATA_WIDTH-1:0] r_hold_data;

   logic [1:0]            w_state_nxt;
   logic [ADDR_WIDTH-1:0] w_base_nxt;
   logic [7:0]            w_row_total_nxt;
   logic [7:0]            w_row_idx_nxt;
   logic [WCW-1:0]        w_word_cnt_nxt;

   logic                  w_last_word;
   logic                  w_last_row;
   logic                  w_in_ready;
   logic                  w_accept;
   logic                  w_writing;
   logic [ROW_W-1:0]      w_row_in;
   logic [ADDR_WIDTH-1:0] w_waddr;
   logic [SRAM_DATA_WIDTH-1:0] w_wdata;

   assign w_writing   = (r_state == S_WRITE);
   assign w_last_word = (r_word_cnt == WCW'(WPR - 1));
   assign w_last_row  = (r_row_idx == r_row_total - 8'd1);
   // The next row may be taken during the final word of a row so rows stream back to back.
   assign w_in_ready  = (r_state == S_WAIT) || (w_writing && w_last_word && !w_last_row);
   assign w_accept    = in_valid && w_in_ready;

   // Row conditioning on acceptance (optional clamp of negative lanes).
   always_comb begin
      w_row_in = in_data;
`ifdef QUANT_WB_RELU_EN
      for (int unsigned i = 0; i < ARRAY_SIZE; i++) begin
         if (in_data[i*OUTPUT_DATA_WIDTH + OUTPUT_DATA_WIDTH - 1]) begin
            w_row_in[i*OUTPUT_DATA_WIDTH +: OUTPUT_DATA_WIDTH] = '0;
         end
      end
`endif
   end

   // Lane i sits at bit i*OUTPUT_DATA_WIDTH, so word k is simply the k-th SRAM-wide slice.
   always_comb begin
      w_wdata = '0;
      for (int unsigned k = 0; k < WPR; k++) begin
         if (r_word_cnt == WCW'(k)) begin
            w_wdata = r_row_buf[k*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
         end
      end
   end

   // Truncation to ADDR_WIDTH gives the silent address wrap.
   assign w_waddr = r_base + ADDR_WIDTH'(32'(r_row_idx) * WPR + 32'(r_word_cnt));

   always_comb begin
      w_state_nxt     = r_state;
      w_base_nxt      = r_base;
      w_row_total_nxt = r_row_total;
      w_row_idx_nxt   = r_row_idx;
      w_word_cnt_nxt  = r_word_cnt;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_base_nxt      = base_addr;
               w_row_total_nxt = row_total;
               w_row_idx_nxt   = 8'd0;
               w_word_cnt_nxt  = '0;
               w_state_nxt     = (row_total == 8'd0) ? S_DONE : S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_accept) begin
               w_word_cnt_nxt = '0;
               w_state_nxt    = S_WRITE;
            end
         end
         S_WRITE: begin
            if (w_last_word) begin
               w_word_cnt_nxt = '0;
               if (w_last_row) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_row_idx_nxt = r_row_idx + 8'd1;
                  w_state_nxt   = w_accept ? S_WRITE : S_WAIT;
               end
            end else begin
               w_word_cnt_nxt = r_word_cnt + WCW'(1);
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_base      <= '0;
         r_row_total <= '0;
         r_row_idx   <= '0;
         r_word_cnt  <= '0;
         r_row_buf   <= '0;
         r_hold_addr <= '0;
         r_hold_data <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_base      <= w_base_nxt;
         r_row_total <= w_row_total_nxt;
         r_row_idx   <= w_row_idx_nxt;
         r_word_cnt  <= w_word_cnt_nxt;
         if (w_accept) begin
            r_row_buf <= w_row_in;
         end
         // Remember the last word written so the SRAM bus holds steady between writes.
         if (w_writing) begin
            r_hold_addr <= w_waddr;
            r_hold_data <= w_wdata;
         end
      end
   end

   assign in_ready   = w_in_ready;
   assign sram_wen   = w_writing;
   assign sram_waddr = w_writing ? w_waddr : r_hold_addr;
   assign sram_wdata = w_writing ? w_wdata : r_hold_data;
   assign busy       = (r_state != S_IDLE);
   assign done       = (r_state == S_DONE);

endmodule

// File: tb/tb_quant_writeback.sv
// Randomized self-checking bench for quant_writeback (default parameters).
// The reference model keeps a queue of pending SRAM writes: each accepted row enqueues its WPR
// words, one write retires per cycle, and the job completes the cycle after the last write.
module tb_quant_writeback;

   localparam int AW  = 10;
   localparam int RW  = 128;
   localparam int DW  = 32;
   localparam int WPR = 4;
   localparam int LPW = 2;
`ifdef QUANT_WB_RELU_EN
   localparam bit RELU = 1'b1;
`else
   localparam bit RELU = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base_addr;
   logic [7:0]    row_total;
   logic          in_valid;
   logic [RW-1:0] in_data;
   logic          in_ready;
   logic          sram_wen;
   logic [AW-1:0] sram_waddr;
   logic [DW-1:0] sram_wdata;
   logic          busy;
   logic          done;

   quant_writeback dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .base_addr  (base_addr),
      .row_total  (row_total),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .sram_wen   (sram_wen),
      .sram_waddr (sram_waddr),
      .sram_wdata (sram_wdata),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } wr_t;

   int n_checks = 0;
   int n_fails  = 0;
   int cyc      = 0;

   // Reference model state.
   wr_t           m_q[$];
   bit            m_active;
   bit            m_done;
   int            m_total;
   int            m_acc;
   logic [AW-1:0] m_base;
   logic [AW-1:0] m_last_a;
   logic [DW-1:0] m_last_d;

   // Observed writes of the current directed job.
   logic [AW-1:0] obs_a[$];
   logic [DW-1:0] obs_d[$];
   int            obs_c[$];
   bit            obs_r[$];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   function automatic void model_reset();
      m_q.delete();
      m_active = 1'b0;
      m_done   = 1'b0;
      m_total  = 0;
      m_acc    = 0;
      m_base   = '0;
      m_last_a = '0;
      m_last_d = '0;
   endfunction

   function automatic bit m_ready();
      return m_active && (m_acc < m_total) && (m_q.size() <= 1);
   endfunction

   function automatic void push_row(input logic [RW-1:0] row);
      wr_t           w;
      logic [15:0]   lane;
      for (int k = 0; k < WPR; k++) begin
         w.a = AW'(int'(m_base) + m_acc * WPR + k);
         w.d = '0;
         for (int j = 0; j < LPW; j++) begin
            lane = row[(k*LPW + j)*16 +: 16];
            if (RELU && lane[15]) lane = 16'h0000;
            w.d[j*16 +: 16] = lane;
         end
         m_q.push_back(w);
      end
   endfunction

   function automatic logic [RW-1:0] rnd_row();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Called just after a falling edge with inputs already driven; compares, advances the model
   // over the next rising edge, then returns at the following falling edge.
   task automatic tick();
      bit  exp_wen;
      bit  exp_ready;
      bit  idle;
      bit  acc;
      bit  nd;
      wr_t h;
      #1;
      if (!rst_n) model_reset();
      exp_wen   = (m_q.size() > 0);
      exp_ready = m_ready();
      check("sram_wen", sram_wen, exp_wen);
      check("in_ready", in_ready, exp_ready);
      check("busy", busy, m_active || m_done);
      check("done", done, m_done);
      if (exp_wen) begin
         check("sram_waddr", sram_waddr, m_q[0].a);
         check("sram_wdata", sram_wdata, m_q[0].d);
      end else begin
         check("hold_waddr", sram_waddr, m_last_a);
         check("hold_wdata", sram_wdata, m_last_d);
      end
      if (sram_wen) begin
         obs_a.push_back(sram_waddr);
         obs_d.push_back(sram_wdata);
         obs_c.push_back(cyc);
         obs_r.push_back(in_ready);
      end
      if (rst_n) begin
         idle = !m_active && !m_done;
         acc  = in_valid && exp_ready;
         nd   = 1'b0;
         if (exp_wen) begin
            h        = m_q.pop_front();
            m_last_a = h.a;
            m_last_d = h.d;
         end
         if (acc) begin
            push_row(in_data);
            m_acc++;
         end
         if (m_active && exp_wen && m_q.size() == 0 && m_acc == m_total) begin
            m_active = 1'b0;
            nd       = 1'b1;
         end
         if (start && idle) begin
            m_base  = base_addr;
            m_total = int'(row_total);
            m_acc   = 0;
            if (m_total == 0) nd = 1'b1;
            else m_active = 1'b1;
         end
         m_done = nd;
      end
      @(negedge clk);
      cyc++;
   endtask

   task automatic clear_obs();
      obs_a.delete();
      obs_d.delete();
      obs_c.delete();
      obs_r.delete();
   endtask

   task automatic run_job(input logic [AW-1:0] base, input int rows, input int pct,
                          input bit fixed, input logic [RW-1:0] fdata);
      start     = 1'b1;
      base_addr = base;
      row_total = 8'(rows);
      in_valid  = 1'b0;
      tick();
      start = 1'b0;
      for (int c = 0; c < 600 && (m_active || m_done); c++) begin
         in_valid  = ($urandom_range(0, 99) < pct);
         in_data   = fixed ? fdata : rnd_row();
         // Stray starts while busy must be ignored.
         start     = ($urandom_range(0, 9) == 0);
         base_addr = AW'($urandom);
         row_total = 8'($urandom);
         tick();
      end
      start    = 1'b0;
      in_valid = 1'b0;
      #1;
      check("idle_after_job", busy, 1'b0);
      @(negedge clk);
      cyc++;
   endtask

   logic [RW-1:0] row;
   logic [DW-1:0] exp36[4];
   logic [AW-1:0] exp39[4];
   logic [DW-1:0] w0;

   initial begin
      model_reset();
      rst_n     = 1'b0;
      start     = 1'b0;
      base_addr = '0;
      row_total = '0;
      in_valid  = 1'b0;
      in_data   = '0;
      @(negedge clk);
      tick();
      tick();
      rst_n = 1'b1;
      tick();

      // Rows presented while idle are dropped.
      in_valid = 1'b1;
      in_data  = rnd_row();
      tick();
      tick();
      in_valid = 1'b0;

      // Single row, lanes 1..8.
      for (int i = 0; i < 8; i++) row[i*16 +: 16] = 16'(i + 1);
      exp36[0] = 32'h0002_0001;
      exp36[1] = 32'h0004_0003;
      exp36[2] = 32'h0006_0005;
      exp36[3] = 32'h0008_0007;
      clear_obs();
      run_job(10'h010, 1, 100, 1'b1, row);
      check("r36_count", obs_a.size(), 4);
      for (int i = 0; i < obs_a.size() && i < 4; i++) begin
         check("r36_addr", obs_a[i], 10'h010 + 10'(i));
         check("r36_data", obs_d[i], exp36[i]);
      end

      // Three rows with valid held high stream without gaps.
      clear_obs();
      run_job(10'h100, 3, 100, 1'b0, '0);
      check("r37_count", obs_a.size(), 12);
      if (obs_c.size() == 12) begin
         check("r37_span", obs_c[11] - obs_c[0], 11);
         for (int i = 0; i < 12; i++) begin
            check("r37_addr", obs_a[i], 10'h100 + 10'(i));
            check("r37_ready", obs_r[i], (i == 3 || i == 7));
         end
      end

      // Empty job.
      clear_obs();
      run_job(10'h055, 0, 100, 1'b0, '0);
      check("r38_no_writes", obs_a.size(), 0);

      // Address wrap.
      exp39[0] = 10'h3FE;
      exp39[1] = 10'h3FF;
      exp39[2] = 10'h000;
      exp39[3] = 10'h001;
      clear_obs();
      run_job(10'h3FE, 1, 100, 1'b0, '0);
      check("r39_count", obs_a.size(), 4);
      for (int i = 0; i < obs_a.size() && i < 4; i++) check("r39_addr", obs_a[i], exp39[i]);

      // Most negative lane 0.
      row = rnd_row();
      row[15:0] = 16'h8000;
      clear_obs();
      run_job(10'h020, 1, 100, 1'b1, row);
      check("r40_count", obs_d.size(), 4);
      if (obs_d.size() > 0) begin
         w0 = obs_d[0];
         check("r40_lane0", w0[15:0], RELU ? 16'h0000 : 16'h8000);
      end

      // Reset during the second write word.
      start     = 1'b1;
      base_addr = 10'h200;
      row_total = 8'd2;
      tick();
      start    = 1'b0;
      in_valid = 1'b1;
      in_data  = rnd_row();
      tick();
      in_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      tick();
      check("r41_wen_in_reset", sram_wen, 1'b0);
      rst_n = 1'b1;
      tick();
      clear_obs();
      run_job(10'h0F0, 2, 70, 1'b0, '0);
      check("r41_post_count", obs_a.size(), 8);

      // Random jobs.
      for (int j = 0; j < 30; j++) begin
         run_job(AW'($urandom), $urandom_range(0, 6), $urandom_range(30, 100), 1'b0, '0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/quant_writeback.md
QUANT_WRITEBACK -- requirements
Module: quant_writeback

Interface
REQ-001 The module SHALL have parameter ARRAY_SIZE, default 8, giving the number of lanes per quantized row.
REQ-002 The module SHALL have parameter OUTPUT_DATA_WIDTH, default 16, giving the width of one quantized lane.
REQ-003 The module SHALL have parameter SRAM_DATA_WIDTH, default 32, giving the width of one SRAM write word.
REQ-004 The module SHALL have parameter ADDR_WIDTH, default 10, giving the width of the SRAM word address.
REQ-005 clk  input  1  is the single clock; all state SHALL update on the rising edge.
REQ-006 rst_n  input  1  is the reset, asynchronous and active-low.
REQ-007 start  input  1  is a one-cycle pulse that begins a job.
REQ-008 base_addr  input  ADDR_WIDTH  is the first SRAM word address of the job, sampled on start.
REQ-009 row_total  input  8  is the number of rows in the job, sampled on start.
REQ-010 in_valid  input  1  indicates that in_data holds a quantized row.
REQ-011 in_data  input  ARRAY_SIZE*OUTPUT_DATA_WIDTH  is a signed quantized row, with lane i at bits [i*16 +: 16].
REQ-012 in_ready  output  1  indicates that the block accepts a row this cycle.
REQ-013 sram_wen  output  1  is the active-high SRAM write strobe.
REQ-014 sram_waddr  output  ADDR_WIDTH  is the SRAM write word address.
REQ-015 sram_wdata  output  SRAM_DATA_WIDTH  is the SRAM write data.
REQ-016 busy  output  1  SHALL be high whenever the state is not IDLE.
REQ-017 done  output  1  is a one-cycle pulse marking job completion.

Function
REQ-018 Words per row SHALL be WPR = ARRAY_SIZE*OUTPUT_DATA_WIDTH/SRAM_DATA_WIDTH (4 at default); lanes per word SHALL be LPW = SRAM_DATA_WIDTH/OUTPUT_DATA_WIDTH.
REQ-019 States SHALL be IDLE, WAIT, WRITE and DONE.
REQ-020 IDLE: start SHALL latch base_addr and row_total and go to DONE if row_total==0, else to WAIT.
REQ-021 A row SHALL be accepted on any cycle with in_valid && in_ready; the accepted row SHALL be copied into an internal row buffer.
REQ-022 in_ready SHALL be high only in WAIT, or in WRITE on the last word (word_cnt==WPR-1) when the current row is not the job's last row.
REQ-023 WAIT: on acceptance the state SHALL go to WRITE with word_cnt=0.
REQ-024 WRITE: each cycle SHALL assert sram_wen and write word word_cnt of the buffered row, then increment word_cnt.
REQ-025 Word k SHALL carry lane k*LPW+j at bits [j*16 +: 16], j=0..LPW-1.
REQ-026 After word WPR-1 the state SHALL go to DONE if all rows are written; otherwise to WRITE with word_cnt=0 if a row was accepted that cycle, else to WAIT.
REQ-027 Timing: a row accepted at cycle t SHALL have its words written at cycles t+1 through t+WPR, giving back-to-back throughput of one row per WPR cycles.
REQ-028 sram_waddr SHALL equal base + row_idx*WPR + word_cnt, computed modulo 2^ADDR_WIDTH so that it wraps silently.
REQ-029 DONE SHALL assert done for exactly one cycle and then go to IDLE.
REQ-030 start SHALL be ignored in any state other than IDLE.
REQ-031 in_valid SHALL be ignored while in_ready is low; data presented in IDLE SHALL be dropped.
REQ-032 Outside WRITE, sram_wen SHALL be 0 and sram_waddr/sram_wdata SHALL hold their last values.

Reset
REQ-033 While rst_n is low: state=IDLE; in_ready, sram_wen, busy and done =0; sram_waddr, sram_wdata, the row buffer and all counters =0.
REQ-034 Reset asserted mid-job SHALL abort the job with no further writes; the first post-reset job SHALL start cleanly.

Configuration
REQ-035 With macro QUANT_WB_RELU_EN defined, each lane SHALL be replaced by 0 if negative before packing; without it, lanes SHALL be written unchanged.

Verification
REQ-036 start, base=0x010, rows=1, lanes 0..7 = 0x0001..0x0008 -> writes 0x010:0x00020001, 0x011:0x00040003, 0x012:0x00060005, 0x013:0x00080007, then done one cycle later.
REQ-037 rows=3 with in_valid held high -> 12 consecutive sram_wen cycles, addresses base..base+11, in_ready high on cycles 4 and 8 of the writes.
REQ-038 rows=0 -> done at start+1 with no writes.
REQ-039 base=0x3FE, rows=1 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
REQ-040 Lane 0 = 0x8000: QUANT_WB_RELU_EN defined -> word0 low half = 0x0000; undefined -> 0x8000.
REQ-041 rst_n low during the second write word -> sram_wen=0 immediately; the next job writes correctly.
